// File: rtl/shiftreg_pkg.sv
// Types shared by the bit-serial link blocks.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    COL_IDLE,
    COL_SHIFT
  } col_state_t;

endpackage

// File: rtl/shiftreg_collect.sv
// Serial-in/parallel-out collector: assembles WIDTH LSB-first bits into a word and
// offers it on a valid/ready port with a sticky overrun flag.
module shiftreg_collect
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             B_bit,
  output logic [WIDTH-1:0] P,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  col_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_p;
  logic             r_p_valid;
  logic             r_overrun;
  logic             w_step, w_flush, w_restart, w_take, w_complete;

  assign w_step     = ena & clear;
  assign w_flush    = ena & ~clear;
  assign w_restart  = w_step & start;
  assign w_take     = w_step & ~start & bit_valid & (r_state == COL_SHIFT);
  assign w_complete = w_take & (r_count == LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = COL_IDLE;
    end else if (w_restart) begin
      w_state_nxt = COL_SHIFT;
    end else if (w_complete) begin
      w_state_nxt = COL_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= COL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_count <= '0;
    end else if (w_flush || w_restart || w_complete) begin
      r_count <= '0;
    end else if (w_take) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Only the upper WIDTH-1 bits need storage; the incoming bit completes the word.
  if (WIDTH > 1) begin : g_shift
    logic [WIDTH-2:0] r_shift;

    assign w_word = {B_bit, r_shift};

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_shift <= '0;
      end else if (w_flush || w_restart) begin
        r_shift <= '0;
      end else if (w_take) begin
        r_shift <= w_word[WIDTH-1:1];
      end
    end
  end else begin : g_bit
    assign w_word = B_bit;
  end

  // Handshake runs regardless of ena; clear outranks completion and p_ready.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_flush) begin
      r_p_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_complete) begin
      if (r_p_valid && !p_ready) begin
        r_overrun <= 1'b1;
      end else begin
        r_p       <= w_word;
        r_p_valid <= 1'b1;
      end
    end else if (r_p_valid && p_ready) begin
      r_p_valid <= 1'b0;
    end
  end

  assign P       = r_p;
  assign p_valid = r_p_valid;
  assign overrun = r_overrun;
  assign busy    = (r_state == COL_SHIFT);

endmodule

// File: tb/tb_shiftreg_collect.sv
// Bench for shiftreg_collect: WIDTH=4 and WIDTH=1 instances share stimulus and are
// checked every cycle against an arithmetic word-assembly model plus literal expectations.
module tb_shiftreg_collect;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       B_bit = 1'b0;
  logic       p_ready = 1'b0;
  logic [3:0] p4;
  logic       pv4, busy4, ovr4;
  logic [0:0] p1;
  logic       pv1, busy1, ovr1;

  int nchk = 0;
  int npass = 0;

  // Model state per instance: [0] WIDTH=4, [1] WIDTH=1
  int m_p[2]   = '{0, 0};
  int m_pv[2]  = '{0, 0};
  int m_ovr[2] = '{0, 0};
  int m_col[2] = '{0, 0};
  int m_acc[2] = '{0, 0};
  int m_n[2]   = '{0, 0};

  shiftreg_collect #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .clear    (clear),
    .start    (start),
    .bit_valid(bit_valid),
    .B_bit    (B_bit),
    .P        (p4),
    .p_valid  (pv4),
    .p_ready  (p_ready),
    .busy     (busy4),
    .overrun  (ovr4)
  );

  shiftreg_collect #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .clear    (clear),
    .start    (start),
    .bit_valid(bit_valid),
    .B_bit    (B_bit),
    .P        (p1),
    .p_valid  (pv1),
    .p_ready  (p_ready),
    .busy     (busy1),
    .overrun  (ovr1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Word = sum of accepted bits weighted by arrival order.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int d = 0; d < 2; d++) begin
        m_p[d] = 0; m_pv[d] = 0; m_ovr[d] = 0; m_col[d] = 0; m_acc[d] = 0; m_n[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int w;
        int word;
        bit done;
        w = (d == 0) ? 4 : 1;
        done = 1'b0;
        word = 0;
        if (ena && !clear) begin
          m_col[d] = 0; m_acc[d] = 0; m_n[d] = 0; m_pv[d] = 0; m_ovr[d] = 0;
        end else begin
          if (ena && start) begin
            m_col[d] = 1; m_acc[d] = 0; m_n[d] = 0;
          end else if (ena && m_col[d] == 1 && bit_valid) begin
            m_acc[d] += int'(B_bit) << m_n[d];
            m_n[d]++;
            if (m_n[d] == w) begin
              done = 1'b1;
              word = m_acc[d];
              m_col[d] = 0; m_acc[d] = 0; m_n[d] = 0;
            end
          end
          if (done) begin
            if (m_pv[d] == 1 && !p_ready) m_ovr[d] = 1;
            else begin
              m_p[d] = word;
              m_pv[d] = 1;
            end
          end else if (m_pv[d] == 1 && p_ready) begin
            m_pv[d] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("w4_P", int'(p4), m_p[0]);
    chk("w4_p_valid", int'(pv4), m_pv[0]);
    chk("w4_busy", int'(busy4), m_col[0]);
    chk("w4_overrun", int'(ovr4), m_ovr[0]);
    chk("w1_P", int'(p1), m_p[1]);
    chk("w1_p_valid", int'(pv1), m_pv[1]);
    chk("w1_busy", int'(busy1), m_col[1]);
    chk("w1_overrun", int'(ovr1), m_ovr[1]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    B_bit = b;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic consume();
    p_ready = 1'b1;
    step();
    p_ready = 1'b0;
  endtask

  // {ena, bit_valid, B_bit}; accepted bits are 1,1,0,0
  logic [2:0] gap_vec[9] = '{3'b111, 3'b010, 3'b100, 3'b111, 3'b001,
                             3'b110, 3'b101, 3'b011, 3'b110};

  initial begin
    step();
    step();
    rstb = 1'b1;
    step();
    chk("rst_P", int'(p4), 0);
    chk("rst_busy", int'(busy4), 0);

    // Basic word, and WIDTH=1 completes on its first bit
    do_start();
    chk("basic_busy", int'(busy4), 1);
    send_bit(1'b1);
    chk("w1_P_first", int'(p1), 1);
    chk("w1_pv_first", int'(pv1), 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("basic_P", int'(p4), 4'b1101);
    chk("basic_pv", int'(pv4), 1);
    chk("basic_busy_drop", int'(busy4), 0);
    consume();
    chk("consumed_pv", int'(pv4), 0);
    chk("consumed_P_hold", int'(p4), 4'b1101);

    // Gaps in bit_valid and ena
    do_start();
    for (int i = 0; i < 9; i++) begin
      ena = gap_vec[i][2];
      bit_valid = gap_vec[i][1];
      B_bit = gap_vec[i][0];
      step();
    end
    ena = 1'b1;
    bit_valid = 1'b0;
    chk("gap_P", int'(p4), 4'b0011);
    chk("gap_pv", int'(pv4), 1);

    // Handshake still works with ena low
    ena = 1'b0;
    p_ready = 1'b1;
    step();
    chk("ena0_consume_pv", int'(pv4), 0);
    ena = 1'b1;
    p_ready = 1'b0;

    // Overrun: 4'hA then 4'h5 without p_ready
    do_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("ovr_P", int'(p4), 4'hA);
    chk("ovr_flag", int'(ovr4), 1);
    clear = 1'b0;
    step();
    clear = 1'b1;
    chk("clr_ovr", int'(ovr4), 0);
    chk("clr_pv", int'(pv4), 0);
    chk("clr_P_hold", int'(p4), 4'hA);

    // Back-to-back with p_ready on the second completion
    do_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    p_ready = 1'b1;
    send_bit(1'b0);
    p_ready = 1'b0;
    chk("b2b_P", int'(p4), 4'h5);
    chk("b2b_pv", int'(pv4), 1);
    chk("b2b_ovr", int'(ovr4), 0);
    consume();

    // Restart mid-word with a same-cycle bit that must be ignored
    do_start();
    send_bit(1'b1); send_bit(1'b1);
    start = 1'b1;
    send_bit(1'b1);
    start = 1'b0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("restart_busy", int'(busy4), 1);
    send_bit(1'b0);
    chk("restart_P", int'(p4), 4'h6);

    // Clear while busy keeps P
    do_start();
    send_bit(1'b1);
    clear = 1'b0;
    step();
    clear = 1'b1;
    chk("clrbusy_busy", int'(busy4), 0);
    chk("clrbusy_pv", int'(pv4), 0);
    chk("clrbusy_P", int'(p4), 4'h6);

    // Reset mid-word takes effect without a clock edge
    do_start();
    send_bit(1'b1); send_bit(1'b0);
    rstb = 1'b0;
    #1;
    chk("arst_P", int'(p4), 0);
    chk("arst_pv", int'(pv4), 0);
    chk("arst_busy", int'(busy4), 0);
    chk("arst_ovr", int'(ovr4), 0);
    step();
    rstb = 1'b1;
    step();

    // WIDTH=1 edge case from a clean state
    do_start();
    chk("w1_busy", int'(busy1), 1);
    send_bit(1'b1);
    chk("w1_P", int'(p1), 1);
    chk("w1_pv", int'(pv1), 1);
    chk("w1_busy_drop", int'(busy1), 0);
    step();
    step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
